// File: rtl/ecc_79_wr_enc.sv
// Write-side SECDED encoder for the ECC-protected FIFO RAM.
// Encodes a 79-bit payload into an 87-bit (87,79) Hsiao-style codeword,
// optionally corrupts one or two bits for test, and hands the word to the
// RAM through an output register backed by a single skid entry.
module ecc_79_wr_enc #(
    parameter int DATA_WIDTH   = 79,
    parameter int PARITY_WIDTH = 8,
    parameter int ADDR_WIDTH   = 5,
    parameter int DEPTH        = 32
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [DATA_WIDTH-1:0]              in_data,
    input  logic                               inj_sbit,
    input  logic                               inj_dbit,
    input  logic [6:0]                         inj_pos,
    output logic                               mem_we,
    input  logic                               mem_ready,
    output logic [ADDR_WIDTH-1:0]              mem_waddr,
    output logic [DATA_WIDTH+PARITY_WIDTH-1:0] mem_wdata,
    input  logic                               addr_clr,
    output logic [15:0]                        wr_cnt,
    output logic [15:0]                        inj_cnt
);

    localparam int CW = DATA_WIDTH + PARITY_WIDTH;

    typedef struct packed {
        logic          inj;
        logic [CW-1:0] cw;
    } entry_t;

    // Parity column for data bit idx: low 7 bits are the bit's position
    // (idx-th integer >= 3 that is not a power of two); the top bit is set
    // when that position has even weight, so every column is odd-weight.
    function automatic logic [PARITY_WIDTH-1:0] col_mask(input int idx);
        int         n;
        logic [6:0] pv;
        n  = 0;
        pv = '0;
        for (int p = 3; p < 128; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (n == idx) pv = 7'(p);
                n++;
            end
        end
        return {~^pv, pv};
    endfunction

    logic [DATA_WIDTH-1:0][PARITY_WIDTH-1:0] terms;
    logic [PARITY_WIDTH-1:0]                 parity;
    logic [CW-1:0]                           flip;
    logic                                    inj_hit;
    logic [6:0]                              pos2;
    entry_t                                  new_e, out_q, skid_q;
    logic                                    out_vld, skid_vld;
    logic                                    accept, xfer;

    for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_col
        localparam logic [PARITY_WIDTH-1:0] COL = col_mask(g);
        assign terms[g] = in_data[g] ? COL : '0;
    end

    // XOR-reduce the selected columns into the check bits
    always_comb begin
        parity = '0;
        for (int i = 0; i < DATA_WIDTH; i++) parity ^= terms[i];
    end

    // Fault-injection mask; out-of-range positions inject nothing
    always_comb begin
        flip    = '0;
        inj_hit = 1'b0;
        pos2    = (inj_pos == 7'(CW - 1)) ? 7'd0 : inj_pos + 7'd1;
        if ((inj_sbit || inj_dbit) && (inj_pos < 7'(CW))) begin
            inj_hit       = 1'b1;
            flip[inj_pos] = 1'b1;
            if (inj_dbit) flip[pos2] = 1'b1;
        end
    end

    assign new_e.cw  = {parity, in_data} ^ flip;
    assign new_e.inj = inj_hit;

    assign in_ready  = !skid_vld;
    assign accept    = in_valid && !skid_vld;
    assign xfer      = out_vld && mem_ready;
    assign mem_we    = out_vld;
    assign mem_wdata = out_q.cw;

    // OUT/SKID buffer: OUT fills first, SKID refills OUT as OUT drains
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q    <= '0;
            out_vld  <= 1'b0;
            skid_q   <= '0;
            skid_vld <= 1'b0;
        end else if (xfer) begin
            if (skid_vld) begin
                out_q    <= skid_q;
                skid_vld <= 1'b0;
            end else if (accept) begin
                out_q <= new_e;
            end else begin
                out_vld <= 1'b0;
            end
        end else if (accept) begin
            if (!out_vld) begin
                out_q   <= new_e;
                out_vld <= 1'b1;
            end else begin
                skid_q   <= new_e;
                skid_vld <= 1'b1;
            end
        end
    end

    // Write address: advances per transfer, wraps at DEPTH, clear wins
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_waddr <= '0;
        end else if (addr_clr) begin
            mem_waddr <= '0;
        end else if (xfer) begin
            mem_waddr <= (mem_waddr == ADDR_WIDTH'(DEPTH - 1)) ? '0
                                                              : mem_waddr + ADDR_WIDTH'(1);
        end
    end

    // Saturating write and injected-write counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_cnt  <= '0;
            inj_cnt <= '0;
        end else if (xfer) begin
            if (wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'd1;
            if (out_q.inj && inj_cnt != 16'hFFFF) inj_cnt <= inj_cnt + 16'd1;
        end
    end

endmodule

// File: doc/ecc_79_wr_enc.md
# ecc_79_wr_enc

Write-side SECDED encoder stage for the ECC-protected FIFO RAM. It accepts 79-bit payloads on a valid/ready handshake and computes the 8 check bits of the (87,79) Hsiao-style code used by the FIFO read-side checker. It optionally injects single- or double-bit faults for test, and writes the 87-bit codeword to the RAM at an auto-incrementing address. One output register plus one skid entry give full throughput, a registered `in_ready`, and no data loss under RAM back-pressure.

## Interface
- `DATA_WIDTH`, default 79: payload width; fixed to 79 by the code definition.
- `PARITY_WIDTH`, default 8: check bits.
- `ADDR_WIDTH`, default 5: RAM address width.
- `DEPTH`, default 32: RAM entries; must be ≤ 2^ADDR_WIDTH.

Ports (name, direction, width, meaning):
- `clk` input 1: the single clock; everything is rising-edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `in_valid` input 1: payload valid.
- `in_ready` output 1: stage can accept.
- `in_data` input 79: payload.
- `inj_sbit` input 1: single-bit injection request, sampled on accept.
- `inj_dbit` input 1: double-bit injection request, sampled on accept.
- `inj_pos` input 7: codeword bit index to corrupt (0..86).
- `mem_we` output 1: RAM write request (valid).
- `mem_ready` input 1: RAM accepts the write this cycle.
- `mem_waddr` output ADDR_WIDTH: write address.
- `mem_wdata` output 87: codeword, {parity[7:0], data[78:0]}.
- `addr_clr` input 1: synchronous write-address clear.
- `wr_cnt` output 16: completed RAM writes, saturating.
- `inj_cnt` output 16: writes carrying an injected fault, saturating.

## Operation
- Column mapping: data bit i uses position pos_i. pos_i is the i-th integer ≥3 that is not a power of two, so pos_0=3, pos_1=5, pos_2=6, pos_3=7, pos_4=9, …, pos_78=86.
- Check bits k=0..6: p[k] = XOR of d[i] over all i whose pos_i has bit k set.
- Check bit 7: p[7] = XOR of d[i] over all i whose popcount(pos_i) is even. This makes every column odd-weight.
- Encoding is computed combinationally on `in_data`. The codeword {p,d} is captured on accept (`in_valid & in_ready`).
- Injection is applied after encoding, to the captured codeword:
  - `inj_dbit`: flip bit `inj_pos` and bit (`inj_pos`+1) mod 87.
  - `inj_sbit` only: flip bit `inj_pos`.
  - If both are set, `inj_dbit` wins.
  - If `inj_pos` > 86, no flip is made and the word is not counted as injected.
- A per-entry flag `inj` travels with the word. `inj_cnt` increments when a word with `inj`=1 is written.
- Buffering: an output register (OUT) and a skid register (SKID); maximum occupancy 2.
  - `in_ready` = !SKID.valid.
  - A transfer occurs on `mem_we & mem_ready`.
  - Accepted word goes to OUT if OUT is empty, or if OUT is transferring this cycle and SKID is empty. Otherwise it goes to SKID.
  - When OUT transfers and SKID is valid, SKID moves to OUT in the same cycle.
  - Words leave in acceptance order.
- `mem_we` = OUT.valid. `mem_wdata` holds stable while `mem_we & !mem_ready`.
- Address: on each transfer `mem_waddr` advances, wrapping from DEPTH-1 to 0.
  - `addr_clr` forces the next address to 0.
  - If `addr_clr` and a transfer happen together, the transfer uses the current address and the next address is 0.
- Counters: `wr_cnt` +1 per transfer and `inj_cnt` +1 per injected transfer. Both stop at 0xFFFF.

## Timing
- Reset values: `in_ready`=1, `mem_we`=0, `mem_waddr`=0, `mem_wdata`=0, `wr_cnt`=0, `inj_cnt`=0; OUT and SKID empty.
- Reset has priority: while `rst_n`=0 nothing is accepted or written.
- Reset asserted mid-operation discards both buffered words. No partial write: `mem_we` is 0 the cycle after `rst_n` is sampled low.
- Latency: a word accepted at edge N appears with `mem_we`=1 after edge N; with `mem_ready`=1 it is written at edge N+1.
- Throughput: one word per cycle while `mem_ready`=1.
- Back-pressure: with `mem_ready`=0, at most 2 words are held. `in_ready` falls the cycle after the second accept and rises the cycle after SKID drains.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with `in_valid`=1 → no `mem_we`; all outputs at reset values; `in_ready`=1.
- Encode: `in_data`=1, no injection → next cycle `mem_wdata`={8'h83, 79'h1}, `mem_waddr`=0. Then `in_data`=79'h8 → parity 8'h07; `in_data`=1<<78 → parity 8'hD6; `wr_cnt`=3.
- Single inject: `in_data`=0, `inj_sbit`=1, `inj_pos`=5 → `mem_wdata`=87'h20; `inj_cnt`=1. Repeat with `inj_pos`=90 → `mem_wdata`=0 and `inj_cnt` stays 1.
- Double inject: `in_data`=0, `inj_dbit`=1 and `inj_sbit`=1, `inj_pos`=86 → `mem_wdata` bits 86 and 0 set, all others 0.
- Back-pressure: stream 10 incrementing words with `mem_ready`=0 for cycles 2–5 →
  - `in_ready`=0 after 2 buffered words;
  - all 10 words written exactly once, in order, at addresses 0..9;
  - `mem_wdata` stable during the stall.
- Wrap and clear: 33 back-to-back writes → addresses 0..31 then 0. Assert `addr_clr` together with a write at address 7 → that write lands at 7 and the next write at 0.
